// File: rtl/byte_word_packer_pkg.sv
// -----------------------------------------------------------------------------
// byte_word_packer_pkg
// Shared constants for the byte packing / byte order swapping stages.
//   DATA_WIDTH_DEFAULT : default packed word width in bits
//   byte_num_of()      : byte lanes in a word of a given width
//   lane_cnt_width()   : width of a counter that indexes those lanes
// -----------------------------------------------------------------------------
package byte_word_packer_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;

    function automatic int byte_num_of(input int data_width);
        return data_width / 8;
    endfunction

    // A lane index needs at least one bit, even for a degenerate one-lane word.
    function automatic int lane_cnt_width(input int byte_num);
        return (byte_num > 1) ? $clog2(byte_num) : 1;
    endfunction

endpackage

// File: rtl/byte_word_packer_out_reg.sv
// -----------------------------------------------------------------------------
// byte_word_packer_out_reg
// Output holding register for the packer, with valid/ready stall handling.
// The word stays stable while m_valid_o && !m_ready_i. A load may coincide
// with a transfer of the current word, which gives back-to-back words.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   load_i         : capture load_*_i this edge (only asserted when free_o)
//   load_data_i    : word to capture
//   load_keep_i    : lane-valid mask to capture
//   load_last_i    : end-of-packet flag to capture
//   m_ready_i      : downstream accepts the word
//   m_data_o/m_keep_o/m_last_o/m_valid_o : registered output word
//   free_o         : register can take a new word at this edge
// -----------------------------------------------------------------------------
module byte_word_packer_out_reg
    import byte_word_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    localparam int BYTE_NUM  = byte_num_of(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic [BYTE_NUM-1:0]   load_keep_i,
    input  logic                  load_last_i,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [BYTE_NUM-1:0]   m_keep_o,
    output logic                  m_last_o,
    output logic                  m_valid_o,
    output logic                  free_o
);

    logic [DATA_WIDTH-1:0] r_data;
    logic [BYTE_NUM-1:0]   r_keep;
    logic                  r_last;
    logic                  r_valid;

    // Empty, or the held word leaves at this edge.
    assign free_o = !r_valid || m_ready_i;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (load_i) begin
            r_data  <= load_data_i;
            r_keep  <= load_keep_i;
            r_last  <= load_last_i;
            r_valid <= 1'b1;
        end else if (r_valid && m_ready_i) begin
            // Payload is left as is; only valid drops after the transfer.
            r_valid <= 1'b0;
        end
    end

    assign m_data_o  = r_data;
    assign m_keep_o  = r_keep;
    assign m_last_o  = r_last;
    assign m_valid_o = r_valid;

endmodule

// File: rtl/byte_word_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
// Packs a valid/ready byte stream into DATA_WIDTH-bit words, first byte in
// the lowest lane. s_last_i closes a word early (partial word, zero-filled
// unused lanes, contiguous keep). One complete word can wait in the
// accumulator while the output register is stalled.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   s_data_i     : input byte
//   s_valid_i    : input byte valid
//   s_last_i     : input byte ends the packet
//   s_ready_o    : packer accepts a byte this cycle (registered state only)
//   m_data_o     : packed word, lane k = k-th byte of the word
//   m_keep_o     : lane-valid mask
//   m_last_o     : word carries the packet's last byte
//   m_valid_o    : output word valid
//   m_ready_i    : downstream accepts the word
// -----------------------------------------------------------------------------
module byte_word_packer
    import byte_word_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    localparam int BYTE_NUM  = byte_num_of(DATA_WIDTH),
    localparam int CNT_W     = lane_cnt_width(BYTE_NUM)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            s_data_i,
    input  logic                  s_valid_i,
    input  logic                  s_last_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [BYTE_NUM-1:0]   m_keep_o,
    output logic                  m_last_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i
);

    logic [DATA_WIDTH-1:0] r_acc_data;
    logic [BYTE_NUM-1:0]   r_acc_keep;
    logic                  r_acc_last;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_pending;
    logic                  r_run;      // holds s_ready_o low until the first edge after reset

    logic [DATA_WIDTH-1:0] w_acc_data_nxt;
    logic [BYTE_NUM-1:0]   w_acc_keep_nxt;
    logic                  w_in_xfer;
    logic                  w_close;
    logic                  w_out_free;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [BYTE_NUM-1:0]   w_load_keep;
    logic                  w_load_last;

    assign s_ready_o = r_run && !r_pending;
    assign w_in_xfer = s_valid_i && s_ready_o;
    assign w_close   = w_in_xfer && ((r_cnt == CNT_W'(BYTE_NUM - 1)) || s_last_i);

    // Accumulator contents with the incoming byte merged into lane r_cnt.
    // NOTE: every always_comb output gets a full default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_acc_data_nxt                 = r_acc_data;
        w_acc_keep_nxt                 = r_acc_keep;
        w_acc_data_nxt[r_cnt*8 +: 8]   = s_data_i;
        w_acc_keep_nxt[r_cnt]          = 1'b1;
    end

    // A pending word has priority; it exists only when no byte is accepted,
    // so the two load sources are never requested together.
    assign w_load      = w_out_free && (r_pending || w_close);
    assign w_load_data = r_pending ? r_acc_data : w_acc_data_nxt;
    assign w_load_keep = r_pending ? r_acc_keep : w_acc_keep_nxt;
    assign w_load_last = r_pending ? r_acc_last : s_last_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc_data <= '0;
            r_acc_keep <= '0;
            r_acc_last <= 1'b0;
            r_cnt      <= '0;
            r_pending  <= 1'b0;
            r_run      <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_pending) begin
                if (w_out_free) begin
                    r_acc_data <= '0;
                    r_acc_keep <= '0;
                    r_acc_last <= 1'b0;
                    r_pending  <= 1'b0;
                end
            end else if (w_close) begin
                r_cnt <= '0;
                if (w_out_free) begin
                    r_acc_data <= '0;
                    r_acc_keep <= '0;
                    r_acc_last <= 1'b0;
                end else begin
                    // Output busy: park the finished word and stop input.
                    r_acc_data <= w_acc_data_nxt;
                    r_acc_keep <= w_acc_keep_nxt;
                    r_acc_last <= s_last_i;
                    r_pending  <= 1'b1;
                end
            end else if (w_in_xfer) begin
                r_acc_data <= w_acc_data_nxt;
                r_acc_keep <= w_acc_keep_nxt;
                r_cnt      <= r_cnt + CNT_W'(1);
            end
        end
    end

    byte_word_packer_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (w_load),
        .load_data_i (w_load_data),
        .load_keep_i (w_load_keep),
        .load_last_i (w_load_last),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .m_keep_o    (m_keep_o),
        .m_last_o    (m_last_o),
        .m_valid_o   (m_valid_o),
        .free_o      (w_out_free)
    );

endmodule

// File: tb/tb_byte_word_packer.sv
// -----------------------------------------------------------------------------
// tb_byte_word_packer
// Directed self-checking bench for byte_word_packer (DATA_WIDTH = 32).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_byte_word_packer;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;

    int n_tests = 0;
    int n_fail  = 0;

    byte_word_packer #(
        .DATA_WIDTH (32)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_data_i  (s_data),
        .s_valid_i (s_valid),
        .s_last_i  (s_last),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_keep_o  (m_keep),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {last, keep, data} as one comparable value.
    function automatic logic [63:0] word(input logic last, input logic [3:0] keep,
                                         input logic [31:0] data);
        return {27'd0, last, keep, data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    int          accepted;
    int          ready_drops;
    int          valid_err;
    int          words;
    logic        rdy_seen;
    logic [31:0] exp_word;

    initial begin
        rst     = 1'b1;
        s_data  = 8'h00;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_out", word(m_last, m_keep, m_data), 64'd0);
        check("rst_valid", {63'd0, m_valid}, 64'd0);
        check("rst_ready_held", {63'd0, s_ready}, 64'd0);
        rst = 1'b0;
        tick();
        check("rst_ready_after", {63'd0, s_ready}, 64'd1);

        // ---------------- full word ----------------
        m_ready = 1'b1;
        send(8'h22, 1'b0);
        send(8'h11, 1'b0);
        send(8'hBB, 1'b0);
        check("full_not_yet", {63'd0, m_valid}, 64'd0);
        send(8'hAA, 1'b0);
        check("full_valid", {63'd0, m_valid}, 64'd1);
        check("full_word", word(m_last, m_keep, m_data), word(1'b0, 4'hF, 32'hAABB1122));
        tick();
        check("full_drop", {63'd0, m_valid}, 64'd0);

        // ---------------- partial word, then restart at lane 0 ----------------
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        check("part_valid", {63'd0, m_valid}, 64'd1);
        check("part_word", word(m_last, m_keep, m_data), word(1'b1, 4'b0011, 32'h00002211));
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        check("part_next", word(m_last, m_keep, m_data), word(1'b0, 4'hF, 32'h66554433));
        // last on the final lane: full keep with last set
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        send(8'h99, 1'b0);
        send(8'hAA, 1'b1);
        check("lane3_last", word(m_last, m_keep, m_data), word(1'b1, 4'hF, 32'hAA998877));
        tick();

        // ---------------- backpressure ----------------
        m_ready  = 1'b0;
        accepted = 0;
        for (int k = 0; k < 12; k++) begin
            rdy_seen = s_ready;
            s_valid  = 1'b1;
            s_data   = 8'(accepted);
            s_last   = 1'b0;
            tick();
            if (rdy_seen) accepted++;
        end
        s_valid = 1'b0;
        check("bp_accepted", 64'(accepted), 64'd8);
        check("bp_ready_low", {63'd0, s_ready}, 64'd0);
        check("bp_word0", word(m_last, m_keep, m_data), word(1'b0, 4'hF, 32'h03020100));
        check("bp_word0_valid", {63'd0, m_valid}, 64'd1);
        m_ready = 1'b1;
        tick();
        check("bp_word1", word(m_last, m_keep, m_data), word(1'b0, 4'hF, 32'h07060504));
        check("bp_word1_valid", {63'd0, m_valid}, 64'd1);
        check("bp_ready_back", {63'd0, s_ready}, 64'd1);
        tick();
        check("bp_drain", {63'd0, m_valid}, 64'd0);
        send(8'h08, 1'b0);
        send(8'h09, 1'b0);
        send(8'h0A, 1'b0);
        send(8'h0B, 1'b0);
        check("bp_resume", word(m_last, m_keep, m_data), word(1'b0, 4'hF, 32'h0B0A0908));
        tick();

        // ---------------- sustained throughput ----------------
        ready_drops = 0;
        valid_err   = 0;
        words       = 0;
        for (int i = 0; i < 1000; i++) begin
            if (s_ready !== 1'b1) ready_drops++;
            s_valid = 1'b1;
            s_data  = 8'(i);
            s_last  = 1'b0;
            tick();
            if (m_valid !== ((i % 4) == 3)) valid_err++;
            if (m_valid === 1'b1) words++;
            if ((i % 4) == 3) begin
                exp_word = {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)};
                check("thru_word", word(m_last, m_keep, m_data), word(1'b0, 4'hF, exp_word));
            end
        end
        s_valid = 1'b0;
        check("thru_ready_drops", 64'(ready_drops), 64'd0);
        check("thru_valid_pattern", 64'(valid_err), 64'd0);
        check("thru_word_count", 64'(words), 64'd250);
        tick();

        // ---------------- same-edge handover ----------------
        m_ready = 1'b0;
        send(8'hA0, 1'b0);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        send(8'hA4, 1'b0);
        send(8'hA5, 1'b0);
        send(8'hA6, 1'b0);
        check("hand_stable", word(m_last, m_keep, m_data), word(1'b0, 4'hF, 32'hA3A2A1A0));
        check("hand_ready", {63'd0, s_ready}, 64'd1);
        m_ready = 1'b1;
        send(8'hA7, 1'b0);
        check("hand_valid", {63'd0, m_valid}, 64'd1);
        check("hand_word", word(m_last, m_keep, m_data), word(1'b0, 4'hF, 32'hA7A6A5A4));
        tick();
        check("hand_drop", {63'd0, m_valid}, 64'd0);

        // ---------------- reset mid-word with a stalled output word ----------------
        m_ready = 1'b0;
        send(8'hC0, 1'b0);
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hC4, 1'b0);
        send(8'hC5, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_out", word(m_last, m_keep, m_data), 64'd0);
        check("rst_mid_valid", {63'd0, m_valid}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // ---------------- reset with a word pending ----------------
        for (int k = 0; k < 8; k++) send(8'hD0 + 8'(k), 1'b0);
        check("rst_pend_ready", {63'd0, s_ready}, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_pend_out", word(m_last, m_keep, m_data), 64'd0);
        check("rst_pend_valid", {63'd0, m_valid}, 64'd0);
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        tick();
        check("rst_pend_no_stale", {63'd0, m_valid}, 64'd0);
        check("rst_pend_ready_back", {63'd0, s_ready}, 64'd1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        check("rst_clean_wait", {63'd0, m_valid}, 64'd0);
        send(8'h04, 1'b0);
        check("rst_clean_word", word(m_last, m_keep, m_data), word(1'b0, 4'hF, 32'h04030201));
        tick();
        check("rst_clean_drop", {63'd0, m_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
